i2c_arbiter: RTL and testbench



---
 rtl/i2c_arbiter.sv | 146 ++++++++++++++
 tb/tb_i2c_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter that lets two requesters share one I2C master.
// The winner's address/direction are latched onto the master port for the
// whole transaction. Completion is pulsed back to the granted requester only.
// Optional abort timer: define I2C_ARB_TIMEOUT_EN to abort a transaction that
// stays in LAUNCH/WAIT_DONE for TIMEOUT_CYCLES clocks (minimum 4).
//
// Handshake: a requester raises reqN with addrN/rwN valid; it is accepted on the
// edge where the arbiter is IDLE and m_ready is high. gntN then stays high until
// the cycle after doneN; reqN/addrN/rwN are ignored after acceptance. Towards the
// master, m_enable high asks for a transfer; the master acknowledges by dropping
// m_ready, which ends m_enable. The master raising m_ready again means finished.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       i2c_reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err_timeout,
  output logic       m_enable,
  output logic [6:0] m_addr,
  output logic       m_rw,
  input  logic       m_ready,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;   // requester that holds the current grant
  logic   last;    // requester granted most recently (1 after reset)
  logic   win;     // arbitration result for this cycle
  logic   load;    // accept a request this cycle
  logic   expire;  // timer says abort this cycle

  // Next-state decode and round-robin choice.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    // With both requesting, the one not served last wins.
    win       = (req0 && req1) ? ~last : req1;
    case (state)
      IDLE: begin
        if ((req0 || req1) && m_ready) begin
          load      = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        if (expire) begin
          state_nxt = DONE;
        end else if (!m_ready) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (expire || m_ready) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register, transaction latch and round-robin pointer.
  always_ff @(posedge clk or posedge i2c_reset) begin
    if (i2c_reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      m_addr <= 7'd0;
      m_rw   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        owner  <= win;
        m_addr <= win ? addr1 : addr0;
        m_rw   <= win ? rw1 : rw0;
      end
      if (state == DONE) begin
        last <= owner;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             to_hit;  // the DONE being entered is an abort

  assign expire = ((state == LAUNCH) || (state == WAIT_DONE)) && (cnt == CNT_LAST);

  // Transaction timer: cleared on acceptance, counts while the master is busy.
  always_ff @(posedge clk or posedge i2c_reset) begin
    if (i2c_reset) begin
      cnt    <= '0;
      to_hit <= 1'b0;
    end else begin
      if (load) begin
        cnt <= '0;
      end else if (((state == LAUNCH) || (state == WAIT_DONE)) && !expire) begin
        cnt <= cnt + 1'b1;
      end
      to_hit <= expire;
    end
  end

  assign err_timeout = (state == DONE) && to_hit;
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;

  // Without the timer TIMEOUT_CYCLES has no effect; the arbiter waits forever.
  if (TIMEOUT_CYCLES < 4) begin : g_timeout_ignored
  end
`endif

  assign gnt0      = (state != IDLE) && !owner;
  assign gnt1      = (state != IDLE) && owner;
  assign done0     = (state == DONE) && !owner;
  assign done1     = (state == DONE) && owner;
  assign m_enable  = (state == LAUNCH);
  assign state_dbg = state;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: scenario tests for i2c_arbiter with an expected-transaction
// queue. Each completion pops the oldest expected {err, id, rw, addr} entry.
module tb_i2c_arbiter;

  localparam int unsigned TO_CYCLES = 16;

  logic       clk = 1'b0;
  logic       i2c_reset;
  logic       req0, req1, rw0, rw1, m_ready;
  logic [6:0] addr0, addr1;
  logic       gnt0, gnt1, done0, done1, err_timeout, m_enable, m_rw;
  logic [6:0] m_addr;
  logic [1:0] state_dbg;

  logic [9:0] exp_q[$];
  int         tests_run = 0;
  int         fail_cnt  = 0;

  // Clock.
  always #5 clk = ~clk;

  i2c_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk(clk), .i2c_reset(i2c_reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1), .rw0(rw0), .rw1(rw1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err_timeout(err_timeout),
    .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_ready(m_ready),
    .state_dbg(state_dbg)
  );

  function automatic logic [9:0] pack_txn(input logic err, input logic id,
                                          input logic rw, input logic [6:0] addr);
    return {err, id, rw, addr};
  endfunction

  function automatic logic [14:0] all_outs();
    return {gnt0, gnt1, done0, done1, err_timeout, m_enable, m_rw, m_addr, state_dbg};
  endfunction

  // Driver: synchronous-looking reset pulse applied on the falling edge.
  task automatic apply_reset();
    @(negedge clk);
    i2c_reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = 7'd0; addr1 = 7'd0; rw0 = 1'b0; rw1 = 1'b0;
    m_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    i2c_reset = 1'b0;
  endtask

  // Driver: I2C master model. Waits for m_enable, drops m_ready after
  // 'launch' cycles of enable, raises it again 'busy' cycles later.
  task automatic master_txn(input int launch, input int busy);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_enable && n < 20);
    if (m_enable) begin
      repeat (launch - 1) @(posedge clk);
      #1 m_ready = 1'b0;
      repeat (busy) @(posedge clk);
      #1 m_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (all_outs() !== 15'd0) begin
      fail_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    apply_reset();
    @(negedge clk);
    tests_run++;
    if (all_outs() !== 15'd0) begin
      fail_cnt++;
      $display("FAIL idle_after_release: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_single();
    int en; int n; logic [9:0] got; logic [9:0] exp_v;
    @(negedge clk);
    req0 = 1'b1; addr0 = 7'h50; rw0 = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    exp_q.push_back(pack_txn(1'b1, 1'b0, 1'b0, 7'h50));
`else
    exp_q.push_back(pack_txn(1'b0, 1'b0, 1'b0, 7'h50));
`endif
    fork
      master_txn(3, 40);
      begin
        @(negedge clk);
        tests_run++;
        if ({gnt0, gnt1, m_enable, m_rw, m_addr} !== {1'b1, 1'b0, 1'b1, 1'b0, 7'h50}) begin
          fail_cnt++;
          $display("FAIL single_grant: gnt0=%b gnt1=%b en=%b rw=%b addr=%h expected 1 0 1 0 50",
                   gnt0, gnt1, m_enable, m_rw, m_addr);
        end
        req0 = 1'b0; addr0 = 7'h11; rw0 = 1'b1;
        en = 1; n = 0;
        @(negedge clk);
        while (m_enable && n < 20) begin
          en++; n++;
          @(negedge clk);
        end
        tests_run++;
        if (en != 3) begin
          fail_cnt++;
          $display("FAIL single_enable_len: got %0d cycles expected 3", en);
        end
        n = 0;
        while (!(done0 || done1) && n < 80) begin
          @(negedge clk); n++;
        end
        tests_run++;
        if (!(done0 || done1)) begin
          fail_cnt++;
          $display("FAIL single_done_wait: no done within budget");
        end else if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL single_sb: done with empty expected queue");
        end else begin
          got = {err_timeout, done1, m_rw, m_addr};
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            fail_cnt++;
            $display("FAIL single_sb: got %h expected %h", got, exp_v);
          end
        end
        @(negedge clk);
        tests_run++;
        if ({gnt0, done0} !== 2'b00) begin
          fail_cnt++;
          $display("FAIL single_release: gnt0=%b done0=%b expected 0 0", gnt0, done0);
        end
      end
    join
  endtask

  task automatic test_req_drop();
    int n; int early; logic [9:0] got; logic [9:0] exp_v;
    @(negedge clk);
    req1 = 1'b1; addr1 = 7'h2A; rw1 = 1'b1;
    exp_q.push_back(pack_txn(1'b0, 1'b1, 1'b1, 7'h2A));
    fork
      master_txn(3, 6);
      begin
        n = 0;
        while (!gnt1 && n < 20) begin
          @(negedge clk); n++;
        end
        tests_run++;
        if (gnt1 !== 1'b1) begin
          fail_cnt++;
          $display("FAIL drop_grant: gnt1=%b expected 1", gnt1);
        end
        repeat (2) @(negedge clk);
        req1 = 1'b0; addr1 = 7'h7F; rw1 = 1'b0;
        early = 0; n = 0;
        while (!(done0 || done1) && n < 40) begin
          if (!gnt1) early++;
          @(negedge clk); n++;
        end
        tests_run++;
        if (early != 0) begin
          fail_cnt++;
          $display("FAIL drop_no_early_release: got %0d cycles without gnt1 expected 0", early);
        end
        tests_run++;
        if (!(done0 || done1)) begin
          fail_cnt++;
          $display("FAIL drop_done_wait: no done within budget");
        end else if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL drop_sb: done with empty expected queue");
        end else begin
          got = {err_timeout, done1, m_rw, m_addr};
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            fail_cnt++;
            $display("FAIL drop_sb: got %h expected %h", got, exp_v);
          end
        end
      end
    join
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n; logic [9:0] got; logic [9:0] exp_v; logic want1;
    apply_reset();
    req0 = 1'b1; addr0 = 7'h10; rw0 = 1'b0;
    req1 = 1'b1; addr1 = 7'h20; rw1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want1 = (k % 2) == 1;
      exp_q.push_back(want1 ? pack_txn(1'b0, 1'b1, 1'b1, 7'h20) : pack_txn(1'b0, 1'b0, 1'b0, 7'h10));
    end
    for (int k = 0; k < 4; k++) begin
      want1 = (k % 2) == 1;
      fork
        master_txn(2, 5);
        begin
          n = 0;
          while (!(gnt0 || gnt1) && n < 20) begin
            @(negedge clk); n++;
          end
          tests_run++;
          if ({gnt0, gnt1} !== {~want1, want1}) begin
            fail_cnt++;
            $display("FAIL rr_order[%0d]: gnt0=%b gnt1=%b expected %b %b", k, gnt0, gnt1, ~want1, want1);
          end
          if (k == 3) begin
            req0 = 1'b0; req1 = 1'b0;
          end
          n = 0;
          while (!(done0 || done1) && n < 40) begin
            @(negedge clk); n++;
          end
          tests_run++;
          if (!(done0 || done1)) begin
            fail_cnt++;
            $display("FAIL rr_done_wait[%0d]: no done within budget", k);
          end else if (exp_q.size() == 0) begin
            fail_cnt++;
            $display("FAIL rr_sb[%0d]: done with empty expected queue", k);
          end else begin
            got = {err_timeout, done1, m_rw, m_addr};
            exp_v = exp_q.pop_front();
            if (got !== exp_v) begin
              fail_cnt++;
              $display("FAIL rr_sb[%0d]: got %h expected %h", k, got, exp_v);
            end
          end
          @(negedge clk);
          tests_run++;
          if ({gnt0, gnt1} !== 2'b00) begin
            fail_cnt++;
            $display("FAIL rr_idle_gap[%0d]: gnt0=%b gnt1=%b expected 0 0", k, gnt0, gnt1);
          end
        end
      join
    end
  endtask

  task automatic test_reset_mid();
    int n; logic [9:0] got; logic [9:0] exp_v;
    @(negedge clk);
    m_ready = 1'b1; req0 = 1'b1; addr0 = 7'h33; rw0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if (state_dbg !== 2'd2) begin
      fail_cnt++;
      $display("FAIL mid_state: got %0d expected 2", state_dbg);
    end
    #2 i2c_reset = 1'b1;
    #1;
    tests_run++;
    if (all_outs() !== 15'd0) begin
      fail_cnt++;
      $display("FAIL mid_async_reset: got %h expected 0", all_outs());
    end
    req0 = 1'b1; addr0 = 7'h44; rw0 = 1'b0;
    req1 = 1'b1; addr1 = 7'h45; rw1 = 1'b1;
    m_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(pack_txn(1'b0, 1'b0, 1'b0, 7'h44));
    @(negedge clk);
    i2c_reset = 1'b0;
    n = 0;
    while (!(gnt0 || gnt1) && n < 10) begin
      @(negedge clk); n++;
    end
    tests_run++;
    if ({gnt0, gnt1} !== 2'b10) begin
      fail_cnt++;
      $display("FAIL mid_first_grant: gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
    end
    req0 = 1'b0; req1 = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    n = 0;
    while (!(done0 || done1) && n < 10) begin
      @(negedge clk); n++;
    end
    tests_run++;
    if (!(done0 || done1)) begin
      fail_cnt++;
      $display("FAIL mid_done_wait: no done within budget");
    end else if (exp_q.size() == 0) begin
      fail_cnt++;
      $display("FAIL mid_sb: done with empty expected queue");
    end else begin
      got = {err_timeout, done1, m_rw, m_addr};
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        fail_cnt++;
        $display("FAIL mid_sb: got %h expected %h", got, exp_v);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ready_wait();
    int early; int n; logic [9:0] got; logic [9:0] exp_v;
    @(negedge clk);
    m_ready = 1'b0; req0 = 1'b1; addr0 = 7'h05; rw0 = 1'b1;
    exp_q.push_back(pack_txn(1'b0, 1'b0, 1'b1, 7'h05));
    early = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) early++;
    end
    tests_run++;
    if (early != 0) begin
      fail_cnt++;
      $display("FAIL ready_hold_off: got %0d grant cycles expected 0", early);
    end
    m_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({gnt0, gnt1, m_enable} !== 3'b101) begin
      fail_cnt++;
      $display("FAIL ready_grant: gnt0=%b gnt1=%b en=%b expected 1 0 1", gnt0, gnt1, m_enable);
    end
    req0 = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    m_ready = 1'b1;
    n = 0;
    while (!(done0 || done1) && n < 10) begin
      @(negedge clk); n++;
    end
    tests_run++;
    if (!(done0 || done1)) begin
      fail_cnt++;
      $display("FAIL ready_done_wait: no done within budget");
    end else if (exp_q.size() == 0) begin
      fail_cnt++;
      $display("FAIL ready_sb: done with empty expected queue");
    end else begin
      got = {err_timeout, done1, m_rw, m_addr};
      exp_v = exp_q.pop_front();
      if (got !== exp_v) begin
        fail_cnt++;
        $display("FAIL ready_sb: got %h expected %h", got, exp_v);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int en; int n_done; int n_err; int en_exp; int done_exp;
    logic [9:0] got; logic [9:0] exp_v;
`ifdef I2C_ARB_TIMEOUT_EN
    en_exp = 16; done_exp = 1;
`else
    en_exp = 41; done_exp = 0;
`endif
    @(negedge clk);
    m_ready = 1'b1; req0 = 1'b1; addr0 = 7'h60; rw0 = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    exp_q.push_back(pack_txn(1'b1, 1'b0, 1'b0, 7'h60));
`endif
    @(negedge clk);
    req0 = 1'b0;
    en = m_enable ? 1 : 0;
    n_done = 0; n_err = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_enable) en++;
      if (err_timeout) n_err++;
      if (done0 || done1) begin
        n_done++;
        got = {err_timeout, done1, m_rw, m_addr};
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL timeout_sb: done with empty expected queue, got %h", got);
        end else begin
          exp_v = exp_q.pop_front();
          if (got !== exp_v) begin
            fail_cnt++;
            $display("FAIL timeout_sb: got %h expected %h", got, exp_v);
          end
        end
      end
    end
    tests_run++;
    if (en != en_exp) begin
      fail_cnt++;
      $display("FAIL timeout_enable_len: got %0d cycles expected %0d", en, en_exp);
    end
    tests_run++;
    if (n_done != done_exp || n_err != done_exp) begin
      fail_cnt++;
      $display("FAIL timeout_pulses: done=%0d err=%0d expected %0d %0d", n_done, n_err, done_exp, done_exp);
    end
    apply_reset();
  endtask

  // Test sequence and final report.
  initial begin
    i2c_reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = 7'd0; addr1 = 7'd0; rw0 = 1'b0; rw1 = 1'b0;
    m_ready = 1'b1;
    test_reset();
    test_single();
    test_req_drop();
    test_round_robin();
    test_reset_mid();
    test_ready_wait();
    test_timeout();
    tests_run++;
    if (exp_q.size() != 0) begin
      fail_cnt++;
      $display("FAIL queue_empty: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
